alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle_if.sv | 33 +++
 rtl/alu_multicycle.sv | 195 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/result bus of the multi-cycle ALU.
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid and
// out_ready are both 1. Valid never waits on ready, and once out_valid is 1
// the result fields hold until the transfer edge.
interface alu_multicycle_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic             carry;
   logic             dbz;
   logic             err;

   // Requester / result consumer side.
   modport master (
      output in_valid, opcode, ain, bin, out_ready,
      input  in_ready, out_valid, out, out_hi, carry, dbz, err
   );

   // ALU side.
   modport slave (
      input  in_valid, opcode, ain, bin, out_ready,
      output in_ready, out_valid, out, out_hi, carry, dbz, err
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle unsigned ALU: add/sub in one working cycle, shift-add multiply
// and restoring divide one bit per cycle. Latency counts the accepting edge as
// edge 1: add/sub/illegal/divide-by-zero report on edge 2, mul/div on edge
// WIDTH+1. Result registers only change when DONE is entered or on reset.
module alu_multicycle #(
   parameter int WIDTH = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   alu_multicycle_if.slave bus,
   output logic [2:0]      o_dbg_state
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0100;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARITH = 3'd1,
      S_MUL   = 3'd2,
      S_DIV   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   // Captured request and iterative datapath.
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_hi;   // mul: partial product high half; div: remainder
   logic [WIDTH-1:0] r_lo;   // mul: multiplier/product low half; div: dividend/quotient
   logic [CW-1:0]    r_cnt;

   // Registered result.
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_out_hi;
   logic             r_carry;
   logic             r_dbz;
   logic             r_err;

   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_sub;
   logic [WIDTH-1:0] w_step_hi;
   logic [WIDTH-1:0] w_step_lo;
   logic             w_load_res;
   logic [WIDTH-1:0] w_res_lo;
   logic [WIDTH-1:0] w_res_hi;
   logic             w_res_c;
   logic             w_res_d;
   logic             w_res_e;

   assign w_accept    = bus.in_valid && (r_state == S_IDLE);
   assign w_last      = (r_cnt == CW'(WIDTH - 1));

   // Shift-add: add the multiplicand when the current multiplier bit is set.
   assign w_mul_sum   = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_b});
   // Restoring divide: bring in the next dividend bit, subtract if it fits.
   // The low WIDTH bits of the difference are exact whenever it is kept.
   assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
   assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

   // One iteration step of the multiplier or divider.
   always_comb begin
      w_step_hi = r_hi;
      w_step_lo = r_lo;
      if (r_state == S_MUL) begin
         {w_step_hi, w_step_lo} = {w_mul_sum, r_lo[WIDTH-1:1]};
      end else if (r_state == S_DIV) begin
         w_step_hi = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
         w_step_lo = {r_lo[WIDTH-2:0], w_div_ge};
      end
   end

   // Next state and the result to latch when DONE is entered.
   always_comb begin
      w_next_state = r_state;
      w_load_res   = 1'b0;
      w_res_lo     = '0;
      w_res_hi     = '0;
      w_res_c      = 1'b0;
      w_res_d      = 1'b0;
      w_res_e      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (bus.opcode)
                  OP_MUL:  w_next_state = S_MUL;
                  OP_DIV:  w_next_state = (bus.bin != '0) ? S_DIV : S_ARITH;
                  default: w_next_state = S_ARITH;
               endcase
            end
         end
         S_ARITH: begin
            w_load_res   = 1'b1;
            w_next_state = S_DONE;
            case (r_op)
               OP_ADD: {w_res_c, w_res_lo} = {1'b0, r_a} + {1'b0, r_b};
               OP_SUB: begin
                  w_res_lo = r_a - r_b;
                  w_res_c  = (r_a < r_b);
               end
               OP_DIV: begin
                  // Only a zero divisor routes a divide through ARITH.
                  w_res_lo = '1;
                  w_res_hi = r_a;
                  w_res_d  = 1'b1;
               end
               default: w_res_e = 1'b1;
            endcase
         end
         S_MUL, S_DIV: begin
            if (w_last) begin
               w_load_res   = 1'b1;
               w_next_state = S_DONE;
               w_res_hi     = w_step_hi;
               w_res_lo     = w_step_lo;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Request capture on acceptance, then one datapath step per MUL/DIV cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_op  <= bus.opcode;
         r_a   <= bus.ain;
         r_b   <= bus.bin;
         r_hi  <= '0;
         r_lo  <= bus.ain;
         r_cnt <= '0;
      end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
         r_hi  <= w_step_hi;
         r_lo  <= w_step_lo;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Result registers, written only on entry to DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out    <= '0;
         r_out_hi <= '0;
         r_carry  <= 1'b0;
         r_dbz    <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_load_res) begin
         r_out    <= w_res_lo;
         r_out_hi <= w_res_hi;
         r_carry  <= w_res_c;
         r_dbz    <= w_res_d;
         r_err    <= w_res_e;
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out       = r_out;
   assign bus.out_hi    = r_out_hi;
   assign bus.carry     = r_carry;
   assign bus.dbz       = r_dbz;
   assign bus.err       = r_err;
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed WIDTH=4 scenarios and a randomized
// WIDTH=8 run scored against a plain-arithmetic reference model.
// Result snapshots pack {latency[4:0], carry, dbz, err, out_hi, out}.
module tb_alu_multicycle;
   logic clock = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   alu_multicycle_if #(.WIDTH(4)) bus4 ();
   alu_multicycle_if #(.WIDTH(8)) bus8 ();
   logic [2:0] dbg4;
   logic [2:0] dbg8;

   alu_multicycle #(.WIDTH(4)) u_dut4 (
      .clock(clock), .reset_n(reset_n), .bus(bus4.slave), .o_dbg_state(dbg4)
   );
   alu_multicycle #(.WIDTH(8)) u_dut8 (
      .clock(clock), .reset_n(reset_n), .bus(bus8.slave), .o_dbg_state(dbg8)
   );

   // ---------------- reference model (WIDTH=8) ----------------
   function automatic logic [23:0] model8(input logic [3:0] op, input int unsigned a,
                                          input int unsigned b);
      int unsigned lo = 0;
      int unsigned hi = 0;
      int unsigned lat = 2;
      logic c = 1'b0;
      logic d = 1'b0;
      logic e = 1'b0;
      case (op)
         4'd1: begin lo = (a + b) % 256; c = (a + b) > 255; end
         4'd2: begin lo = (a + 256 - b) % 256; c = (a < b); end
         4'd3: begin lo = (a * b) % 256; hi = (a * b) / 256; lat = 9; end
         4'd4: begin
            if (b == 0) begin lo = 255; hi = a; d = 1'b1; end
            else begin lo = a / b; hi = a % b; lat = 9; end
         end
         default: e = 1'b1;
      endcase
      return {5'(lat), c, d, e, 8'(hi), 8'(lo)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic run_op4(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int stall, output logic [15:0] snap,
                          output logic [15:0] snap_late);
      int lat;
      @(negedge clock);
      bus4.opcode = op; bus4.ain = a; bus4.bin = b;
      bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus4.in_valid = 1'b0;
      bus4.opcode = 4'($urandom); bus4.ain = 4'($urandom); bus4.bin = 4'($urandom);
      lat = 1;
      while (bus4.out_valid !== 1'b1 && lat < 30) begin
         @(negedge clock);
         lat++;
      end
      snap = {5'(lat), bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out};
      repeat (stall) @(negedge clock);
      snap_late = {5'(lat), bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out};
      bus4.out_ready = 1'b1;
      @(negedge clock);
      bus4.out_ready = 1'b0;
   endtask

   task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int stall, output logic [23:0] snap,
                          output logic [23:0] snap_late);
      int lat;
      @(negedge clock);
      bus8.opcode = op; bus8.ain = a; bus8.bin = b;
      bus8.in_valid = 1'b1; bus8.out_ready = 1'($urandom);
      @(posedge clock);
      @(negedge clock);
      bus8.in_valid = 1'b0;
      bus8.ain = 8'($urandom); bus8.bin = 8'($urandom);
      lat = 1;
      while (bus8.out_valid !== 1'b1 && lat < 30) begin
         // out_ready toggling while no result is present must be harmless.
         bus8.out_ready = 1'($urandom);
         bus8.in_valid  = 1'($urandom);
         @(negedge clock);
         lat++;
      end
      bus8.in_valid = 1'b0;
      snap = {5'(lat), bus8.carry, bus8.dbz, bus8.err, bus8.out_hi, bus8.out};
      bus8.out_ready = 1'b0;
      repeat (stall) @(negedge clock);
      snap_late = {5'(lat), bus8.carry, bus8.dbz, bus8.err, bus8.out_hi, bus8.out};
      bus8.out_ready = 1'b1;
      @(negedge clock);
      bus8.out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [11:0] o4;
      logic [19:0] o8;
      reset_n = 1'b0;
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.opcode = '0; bus4.ain = '0; bus4.bin = '0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.opcode = '0; bus8.ain = '0; bus8.bin = '0;
      repeat (3) @(negedge clock);
      o4 = {bus4.out_valid, bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out};
      o8 = {bus8.out_valid, bus8.carry, bus8.dbz, bus8.err, bus8.out_hi, bus8.out};
      checks++; if (o4 !== '0) begin errors++; $display("FAIL reset_out4: got %h expected 0", o4); end
      checks++; if (o8 !== '0) begin errors++; $display("FAIL reset_out8: got %h expected 0", o8); end
      // Release and present the first request for the very next edge.
      reset_n = 1'b1;
      bus4.opcode = 4'b0001; bus4.ain = 4'd2; bus4.bin = 4'd3; bus4.in_valid = 1'b1;
      #1;
      checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b expected 1", bus4.in_ready); end
      checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b expected 1", bus8.in_ready); end
      @(negedge clock);
      bus4.in_valid = 1'b0;
      checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL first_accept: in_ready got %b expected 0", bus4.in_ready); end
      @(negedge clock);
      checks++; if ({bus4.out_valid, bus4.out} !== {1'b1, 4'd5}) begin
         errors++; $display("FAIL first_result: got valid=%b out=%0d expected valid=1 out=5", bus4.out_valid, bus4.out);
      end
      bus4.out_ready = 1'b1;
      @(negedge clock);
      bus4.out_ready = 1'b0;
   endtask

   task automatic test_add();
      logic [3:0]  ta [3] = '{4'd9, 4'd0, 4'd15};
      logic [3:0]  tb_ [3] = '{4'd8, 4'd0, 4'd1};
      logic [15:0] te [3] = '{{5'd2, 3'b100, 4'd0, 4'd1}, {5'd2, 3'b000, 4'd0, 4'd0},
                              {5'd2, 3'b100, 4'd0, 4'd0}};
      logic [15:0] s, sl;
      for (int i = 0; i < 3; i++) begin
         run_op4(4'b0001, ta[i], tb_[i], 2, s, sl);
         checks++; if (s !== te[i]) begin errors++; $display("FAIL add[%0d]: got %h expected %h", i, s, te[i]); end
         checks++; if (sl !== te[i]) begin errors++; $display("FAIL add_hold[%0d]: got %h expected %h", i, sl, te[i]); end
      end
   endtask

   task automatic test_sub();
      logic [3:0]  ta [4] = '{4'd3, 4'd7, 4'd5, 4'd0};
      logic [3:0]  tb_ [4] = '{4'd5, 4'd2, 4'd5, 4'd15};
      logic [15:0] te [4] = '{{5'd2, 3'b100, 4'd0, 4'd14}, {5'd2, 3'b000, 4'd0, 4'd5},
                              {5'd2, 3'b000, 4'd0, 4'd0}, {5'd2, 3'b100, 4'd0, 4'd1}};
      logic [15:0] s, sl;
      for (int i = 0; i < 4; i++) begin
         run_op4(4'b0010, ta[i], tb_[i], 1, s, sl);
         checks++; if (s !== te[i]) begin errors++; $display("FAIL sub[%0d]: got %h expected %h", i, s, te[i]); end
      end
   endtask

   task automatic test_mul();
      logic [3:0]  ta [4] = '{4'd15, 4'd0, 4'd3, 4'd8};
      logic [3:0]  tb_ [4] = '{4'd15, 4'd7, 4'd5, 4'd2};
      logic [15:0] te [4] = '{{5'd5, 3'b000, 4'd14, 4'd1}, {5'd5, 3'b000, 4'd0, 4'd0},
                              {5'd5, 3'b000, 4'd0, 4'd15}, {5'd5, 3'b000, 4'd1, 4'd0}};
      logic [15:0] s, sl;
      for (int i = 0; i < 4; i++) begin
         run_op4(4'b0011, ta[i], tb_[i], 3, s, sl);
         checks++; if (s !== te[i]) begin errors++; $display("FAIL mul[%0d]: got %h expected %h", i, s, te[i]); end
         checks++; if (sl !== te[i]) begin errors++; $display("FAIL mul_hold[%0d]: got %h expected %h", i, sl, te[i]); end
      end
   endtask

   task automatic test_div();
      logic [3:0]  ta [5] = '{4'd13, 4'd3, 4'd15, 4'd0, 4'd13};
      logic [3:0]  tb_ [5] = '{4'd4, 4'd15, 4'd1, 4'd0, 4'd0};
      logic [15:0] te [5] = '{{5'd5, 3'b000, 4'd1, 4'd3}, {5'd5, 3'b000, 4'd3, 4'd0},
                              {5'd5, 3'b000, 4'd0, 4'd15}, {5'd2, 3'b010, 4'd0, 4'd15},
                              {5'd2, 3'b010, 4'd13, 4'd15}};
      logic [15:0] s, sl;
      for (int i = 0; i < 5; i++) begin
         run_op4(4'b0100, ta[i], tb_[i], 1, s, sl);
         checks++; if (s !== te[i]) begin errors++; $display("FAIL div[%0d]: got %h expected %h", i, s, te[i]); end
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [11:0] o4;
      @(negedge clock);
      bus4.opcode = 4'b0011; bus4.ain = 4'd15; bus4.bin = 4'd15; bus4.in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus4.in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      o4 = {bus4.out_valid, bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out};
      checks++; if (o4 !== '0) begin errors++; $display("FAIL midmul_reset_out: got %h expected 0", o4); end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL midmul_in_ready: got %b expected 1", bus4.in_ready); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         checks++; if ({bus4.out_valid, bus4.out_hi, bus4.out} !== '0) begin
            errors++; $display("FAIL midmul_no_result[%0d]: got valid=%b hi=%0d out=%0d expected all 0", i, bus4.out_valid, bus4.out_hi, bus4.out);
         end
      end
   endtask

   task automatic test_illegal_hold();
      logic [10:0] held;
      int lat;
      @(negedge clock);
      bus4.opcode = 4'b0111; bus4.ain = 4'd5; bus4.bin = 4'd3; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      // Keep offering a different request; it must be ignored.
      bus4.opcode = 4'b0001; bus4.ain = 4'd1; bus4.bin = 4'd1;
      lat = 1;
      while (bus4.out_valid !== 1'b1 && lat < 30) begin
         @(negedge clock);
         lat++;
      end
      held = {bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out};
      checks++; if ({5'(lat), held} !== {5'd2, 3'b001, 4'd0, 4'd0}) begin
         errors++; $display("FAIL illegal: got %h expected %h", {5'(lat), held}, {5'd2, 3'b001, 4'd0, 4'd0});
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checks++; if ({bus4.out_valid, bus4.in_ready, bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out} !== {2'b10, 3'b001, 8'd0}) begin
            errors++; $display("FAIL illegal_hold[%0d]: got valid=%b in_ready=%b fields=%h expected valid=1 in_ready=0 fields=%h",
                               i, bus4.out_valid, bus4.in_ready, {bus4.carry, bus4.dbz, bus4.err, bus4.out_hi, bus4.out}, held);
         end
      end
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b1;
      @(negedge clock);
      bus4.out_ready = 1'b0;
      checks++; if ({bus4.out_valid, bus4.in_ready} !== 2'b01) begin
         errors++; $display("FAIL illegal_release: got valid=%b in_ready=%b expected valid=0 in_ready=1", bus4.out_valid, bus4.in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL no_queue[%0d]: out_valid got %b expected 0", i, bus4.out_valid); end
      end
   endtask

   // ---------------- scoreboard-driven random run (WIDTH=8) ----------------
   task automatic test_random8();
      logic [23:0] exp_q[$];
      logic [23:0] s, sl, exp;
      logic [3:0]  op;
      logic [7:0]  a, b;
      int          r;
      for (int i = 0; i < 150; i++) begin
         r  = $urandom_range(0, 9);
         op = (r < 8) ? 4'((r % 4) + 1) : 4'($urandom_range(0, 15));
         a  = 8'($urandom_range(0, 255));
         b  = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         exp_q.push_back(model8(op, a, b));
         run_op8(op, a, b, $urandom_range(0, 3), s, sl);
         exp = exp_q.pop_front();
         checks++; if (s !== exp) begin
            errors++; $display("FAIL rand[%0d] op=%0d a=%0d b=%0d: got %h expected %h", i, op, a, b, s, exp);
         end
         checks++; if (sl !== exp) begin
            errors++; $display("FAIL rand_hold[%0d]: got %h expected %h", i, sl, exp);
         end
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_div();
      test_reset_mid_mul();
      test_illegal_hold();
      test_random8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached before the sequence completed");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
